// File: rtl/lc3_data_mem.sv
// lc3_data_mem: fixed-latency 16-bit data memory responder for the LC-3
// memory-access stage. One request at a time: IDLE accepts, BUSY counts out
// the latency, DONE presents a one-cycle completion (and error) pulse.
// Addresses above the implemented range are flagged rather than aliased.
module lc3_data_mem #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Data_en,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    input  logic        Data_rd,
    output logic [15:0] Data_dout,
    output logic        Data_ready,
    output logic        Data_err,
    output logic        Data_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Counter preload: LATENCY-1 decrements in BUSY, then one access edge.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Request registers, loaded only on the accepting edge.
    logic [15:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic        rd_q, rd_d;

    // Registered outputs.
    logic [15:0] dout_q, dout_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    // Storage and its write port.
    logic [15:0]       mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_idx;
    logic              in_range;

    // Decode of the captured request address.
    assign mem_idx  = addr_q[ADDR_W-1:0];
    assign in_range = ((addr_q >> ADDR_W) == 16'd0);

    // Next-state, request capture, access and output computation.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rd_d    = rd_q;
        dout_d  = dout_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Data_en) begin
                    addr_d = Data_addr;
                    din_d  = Data_din;
                    // Only a clean 0 selects a write; X/Z falls through as a read.
                    if (Data_rd == 1'b0) begin
                        rd_d = 1'b0;
                    end else begin
                        rd_d = 1'b1;
                    end
                    cnt_d   = CNT_INIT;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    if (in_range) begin
                        if (rd_q) begin
                            dout_d = mem[mem_idx];
                        end else begin
                            mem_we = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (rd_q) begin
                            dout_d = 16'h0000;
                        end
                    end
                end
            end

            S_DONE: begin
                // Completion pulse lasts one cycle; new requests wait for IDLE.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Control, request and output registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values of its neighbours.
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            din_q   <= 16'h0000;
            rd_q    <= 1'b0;
            dout_q  <= 16'h0000;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rd_q    <= rd_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Memory write port; a write commits on the BUSY->DONE edge.
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset; contents survive reset, and since
        // state_q resets asynchronously to IDLE, mem_we drops immediately and
        // a pending write is discarded.
        if (mem_we) begin
            mem[mem_idx] <= din_q;
        end
    end

    assign Data_dout  = dout_q;
    assign Data_ready = ready_q;
    assign Data_err   = err_q;
    assign Data_busy  = busy_q;

endmodule

// File: tb/tb_lc3_data_mem.sv
// Bench for lc3_data_mem: three instances (LATENCY 2, 1 and 15) sharing the
// clock, reset and request fields, each with its own Data_en. A reference
// model (per-instance word map plus last read value) predicts every output
// on every cycle of each request.
module tb_lc3_data_mem;

    localparam int ADDR_W = 8;
    localparam int NINST  = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        en [NINST];
    logic [15:0] addr;
    logic [15:0] din;
    logic        rd;

    logic [15:0] dout  [NINST];
    logic        ready [NINST];
    logic        err   [NINST];
    logic        busy  [NINST];

    int checks = 0;
    int errors = 0;

    // Reference model: stored words keyed by inst*65536+addr, last read value.
    logic [15:0] ref_mem [int];
    logic [15:0] last_dout [NINST];

    always #5 clock = ~clock;

    lc3_data_mem #(.ADDR_W(ADDR_W), .LATENCY(2)) u_lat2 (
        .clock(clock), .reset(reset), .Data_en(en[0]), .Data_addr(addr),
        .Data_din(din), .Data_rd(rd), .Data_dout(dout[0]), .Data_ready(ready[0]),
        .Data_err(err[0]), .Data_busy(busy[0])
    );

    lc3_data_mem #(.ADDR_W(ADDR_W), .LATENCY(1)) u_lat1 (
        .clock(clock), .reset(reset), .Data_en(en[1]), .Data_addr(addr),
        .Data_din(din), .Data_rd(rd), .Data_dout(dout[1]), .Data_ready(ready[1]),
        .Data_err(err[1]), .Data_busy(busy[1])
    );

    lc3_data_mem #(.ADDR_W(ADDR_W), .LATENCY(15)) u_lat15 (
        .clock(clock), .reset(reset), .Data_en(en[2]), .Data_addr(addr),
        .Data_din(din), .Data_rd(rd), .Data_dout(dout[2]), .Data_ready(ready[2]),
        .Data_err(err[2]), .Data_busy(busy[2])
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    function automatic bit addr_ok(input logic [15:0] a);
        return int'(a) < (1 << ADDR_W);
    endfunction

    // Called right after the accepting edge. Checks every cycle up to and
    // including the return to IDLE, then updates the model. With hold set,
    // Data_en stays high and the fields switch to a read of hold_addr.
    task automatic observe(input int i, input logic [15:0] a, input logic [15:0] d,
                           input logic r, input bit hold, input logic [15:0] hold_addr);
        int          lat;
        int          key;
        bit          ok;
        logic [15:0] exp_dout;
        lat = lat_of(i);
        key = i * 65536 + int'(a);
        ok  = addr_ok(a);
        if (r) begin
            if (!ok) exp_dout = 16'h0000;
            else if (ref_mem.exists(key)) exp_dout = ref_mem[key];
            else begin
                $display("FAIL model: read of unwritten addr %h", a);
                $fatal(1);
            end
        end else begin
            exp_dout = last_dout[i];
        end

        @(negedge clock);
        if (hold) begin
            addr = hold_addr;
            rd   = 1'b1;
        end else begin
            en[i] = 1'b0;
        end
        check($sformatf("i%0d busy@0", i), 16'(busy[i]), 16'd1);
        check($sformatf("i%0d ready@0", i), 16'(ready[i]), 16'd0);

        for (int c = 1; c <= lat; c++) begin
            @(negedge clock);
            check($sformatf("i%0d busy@%0d", i, c), 16'(busy[i]), 16'd1);
            if (c < lat) begin
                check($sformatf("i%0d ready@%0d", i, c), 16'(ready[i]), 16'd0);
                check($sformatf("i%0d err@%0d", i, c), 16'(err[i]), 16'd0);
                check($sformatf("i%0d dout_hold@%0d", i, c), dout[i], last_dout[i]);
            end else begin
                check($sformatf("i%0d ready a=%h", i, a), 16'(ready[i]), 16'd1);
                check($sformatf("i%0d err a=%h", i, a), 16'(err[i]), 16'(!ok));
                check($sformatf("i%0d dout a=%h", i, a), dout[i], exp_dout);
            end
        end

        last_dout[i] = exp_dout;
        if (!r && ok) ref_mem[key] = d;

        @(negedge clock);
        check($sformatf("i%0d ready_clr", i), 16'(ready[i]), 16'd0);
        check($sformatf("i%0d err_clr", i), 16'(err[i]), 16'd0);
        check($sformatf("i%0d busy_clr", i), 16'(busy[i]), 16'd0);
        check($sformatf("i%0d dout_after", i), dout[i], exp_dout);
    endtask

    // Caller is at a negedge; the request is accepted on the next rising edge.
    task automatic run_req(input int i, input logic [15:0] a, input logic [15:0] d,
                           input logic r);
        addr  = a;
        din   = d;
        rd    = r;
        en[i] = 1'b1;
        @(posedge clock);
        observe(i, a, d, r, 1'b0, 16'h0000);
    endtask

    task automatic random_req(input int i);
        logic [15:0] a;
        logic        r;
        bit          found;
        r = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 4) == 0) a = 16'($urandom_range(256, 65535));
        else a = 16'($urandom_range(0, 31));
        if (r && addr_ok(a)) begin
            found = 1'b0;
            for (int t = 0; t < 64 && !found; t++) begin
                a = 16'($urandom_range(0, 31));
                found = ref_mem.exists(i * 65536 + int'(a));
            end
            if (!found) r = 1'b0;
        end
        run_req(i, a, 16'($urandom), r);
        repeat ($urandom_range(0, 2)) @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < NINST; i++) begin
            en[i]        = 1'b0;
            last_dout[i] = 16'h0000;
        end
        addr  = 16'h0000;
        din   = 16'h0000;
        rd    = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clock);

        for (int i = 0; i < NINST; i++) begin
            check($sformatf("i%0d rst dout", i), dout[i], 16'h0000);
            check($sformatf("i%0d rst ready", i), 16'(ready[i]), 16'd0);
            check($sformatf("i%0d rst err", i), 16'(err[i]), 16'd0);
            check($sformatf("i%0d rst busy", i), 16'(busy[i]), 16'd0);
        end
        reset = 1'b1;
        @(negedge clock);

        // Write then read back, out-of-range write and read.
        run_req(0, 16'h0012, 16'hBEEF, 1'b0);
        run_req(0, 16'h0012, 16'h0000, 1'b1);
        run_req(0, 16'h0112, 16'h1234, 1'b0);
        run_req(0, 16'h0012, 16'h0000, 1'b1);
        run_req(0, 16'h0112, 16'h0000, 1'b1);
        // Range boundary.
        run_req(0, 16'h00FF, 16'hA5A5, 1'b0);
        run_req(0, 16'h0100, 16'h5A5A, 1'b0);
        run_req(0, 16'h00FF, 16'h0000, 1'b1);
        run_req(0, 16'hFFFF, 16'h0000, 1'b1);

        // Data_en held through BUSY/DONE: the second request waits for IDLE.
        run_req(0, 16'h0034, 16'h3434, 1'b0);
        addr  = 16'h0012;
        din   = 16'h0000;
        rd    = 1'b1;
        en[0] = 1'b1;
        @(posedge clock);
        observe(0, 16'h0012, 16'h0000, 1'b1, 1'b1, 16'h0034);
        @(posedge clock);
        observe(0, 16'h0034, 16'h0000, 1'b1, 1'b0, 16'h0000);

        // Reset during a write: outputs clear at once, memory keeps old word.
        run_req(0, 16'h0040, 16'h1111, 1'b0);
        run_req(0, 16'h0012, 16'h0000, 1'b1);
        addr  = 16'h0040;
        din   = 16'h5555;
        rd    = 1'b0;
        en[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        en[0] = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_mid dout", dout[0], 16'h0000);
        check("rst_mid busy", 16'(busy[0]), 16'd0);
        check("rst_mid ready", 16'(ready[0]), 16'd0);
        for (int i = 0; i < NINST; i++) last_dout[i] = 16'h0000;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_req(0, 16'h0040, 16'h0000, 1'b1);

        // Latency-1 and latency-15 builds.
        run_req(1, 16'h0007, 16'h7777, 1'b0);
        run_req(1, 16'h0007, 16'h0000, 1'b1);
        run_req(1, 16'h0207, 16'h0000, 1'b1);
        run_req(2, 16'h0009, 16'h9999, 1'b0);
        run_req(2, 16'h0009, 16'h0000, 1'b1);
        run_req(2, 16'h8009, 16'h0000, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) random_req(0);
        for (int n = 0; n < 20; n++) random_req(1);
        for (int n = 0; n < 6; n++) random_req(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
